// File: rtl/bcd_up_counter_if.sv
// Control, data and status bundle for bcd_up_counter.
// The master drives the controls and load data; the counter (slave) returns Q, CO and ERR.
interface bcd_up_counter_if #(
  parameter int DIGITS = 2
);
  logic                  CS;
  logic                  LD;
  logic                  EN;
  logic                  CI;
  logic [4*DIGITS-1:0]   D;
  logic [4*DIGITS-1:0]   Q;
  logic                  CO;
  logic                  ERR;

  modport master (output CS, LD, EN, CI, D, input Q, CO, ERR);
  modport slave  (input CS, LD, EN, CI, D, output Q, CO, ERR);
endinterface

// File: rtl/bcd_up_counter.sv
// Cascadable multi-digit decade up counter with clear, parallel load, enable and carry.
// Once a non-BCD digit has been loaded, ERR freezes counting until it is cleared or reloaded.
module bcd_up_counter #(
  parameter int DIGITS = 2
) (
  input  logic              CLK,
  input  logic              CDN,
  bcd_up_counter_if.slave   bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0] q_q, q_d;
  logic         err_q, err_d;
  logic [W-1:0] inc_val;
  logic         all_nines;
  logic         d_bad;
  logic         count_en;

  // all_nines doubles as the ripple enable: a digit advances only while
  // every lower digit is 9, and after the loop it flags an all-9s value.
  always_comb begin
    inc_val   = q_q;
    all_nines = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (all_nines) begin
        inc_val[4*k +: 4] = (q_q[4*k +: 4] == 4'd9) ? 4'd0 : q_q[4*k +: 4] + 4'd1;
      end
      all_nines = all_nines & (q_q[4*k +: 4] == 4'd9);
    end
  end

  always_comb begin
    d_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      d_bad = d_bad | (bus.D[4*k +: 4] > 4'd9);
    end
  end

  assign count_en = bus.EN & bus.CI & ~err_q;

  always_comb begin
    q_d   = q_q;
    err_d = err_q;
    if (bus.CS) begin
      q_d   = '0;
      err_d = 1'b0;
    end else if (bus.LD) begin
      q_d   = bus.D;
      err_d = d_bad;
    end else if (count_en) begin
      q_d   = inc_val;
    end
  end

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.ERR = err_q;
  assign bus.CO  = count_en & all_nines;
endmodule

// File: tb/tb_bcd_up_counter.sv
// Self-checking bench for bcd_up_counter: directed scenarios plus randomized traffic
// compared every cycle against an integer-arithmetic model of the counter.
module tb_bcd_up_counter;
  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
  localparam int MODULO = 100;
  localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

  logic clk;
  logic cdn;
  logic chk_en;
  int   tests_run;
  int   failures;

  logic [W-1:0] m_q;
  logic         m_err;

  bcd_up_counter_if #(.DIGITS(DIGITS)) bus ();
  bcd_up_counter_if #(.DIGITS(DIGITS)) lo_if ();
  bcd_up_counter_if #(.DIGITS(DIGITS)) hi_if ();

  assign hi_if.CI = lo_if.CO;

  bcd_up_counter #(.DIGITS(DIGITS)) dut    (.CLK(clk), .CDN(cdn), .bus(bus));
  bcd_up_counter #(.DIGITS(DIGITS)) dut_lo (.CLK(clk), .CDN(cdn), .bus(lo_if));
  bcd_up_counter #(.DIGITS(DIGITS)) dut_hi (.CLK(clk), .CDN(cdn), .bus(hi_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int n = 0;
    for (int k = DIGITS - 1; k >= 0; k--) n = n * 10 + int'(v[4*k +: 4]);
    return n;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int n);
    logic [W-1:0] v = '0;
    for (int k = 0; k < DIGITS; k++) begin
      v[4*k +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return v;
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    for (int k = 0; k < DIGITS; k++) if (v[4*k +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: the count is held as a plain integer modulo 10^DIGITS.
  always @(posedge clk or negedge cdn) begin
    if (!cdn) begin
      m_q   <= '0;
      m_err <= 1'b0;
    end else if (bus.CS) begin
      m_q   <= '0;
      m_err <= 1'b0;
    end else if (bus.LD) begin
      m_q   <= bus.D;
      m_err <= has_bad_digit(bus.D);
    end else if (bus.EN && bus.CI && !m_err) begin
      m_q   <= int_to_bcd((bcd_to_int(m_q) + 1) % MODULO);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cycle_q",   32'(bus.Q),   32'(m_q));
      checkOutput("cycle_err", 32'(bus.ERR), 32'(m_err));
      checkOutput("cycle_co",  32'(bus.CO),
                  32'(bus.EN & bus.CI & ~m_err & (m_q == ALL9)));
    end
  end

  task automatic applyStimulus(input logic cs, input logic ld, input logic en,
                               input logic ci, input logic [W-1:0] d);
    @(negedge clk);
    #1;
    bus.CS = cs;
    bus.LD = ld;
    bus.EN = en;
    bus.CI = ci;
    bus.D  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] rd;
    tests_run = 0;
    failures  = 0;
    chk_en    = 1'b0;
    cdn       = 1'b0;
    bus.CS = 1'b0; bus.LD = 1'b0; bus.EN = 1'b0; bus.CI = 1'b0; bus.D = '0;
    lo_if.CS = 1'b0; lo_if.LD = 1'b0; lo_if.EN = 1'b0; lo_if.CI = 1'b0; lo_if.D = '0;
    hi_if.CS = 1'b0; hi_if.LD = 1'b0; hi_if.EN = 1'b0; hi_if.D = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 cdn = 1'b1;
    chk_en = 1'b1;
    checkOutput("reset_q",   32'(bus.Q),   32'h00);
    checkOutput("reset_err", 32'(bus.ERR), 32'h0);

    // Asynchronous clear mid-count, then release straight into counting
    applyStimulus(0, 1, 0, 1, 8'h47);
    checkOutput("load_47", 32'(bus.Q), 32'h47);
    cdn = 1'b0;
    #2;
    checkOutput("async_clr_q",   32'(bus.Q),   32'h00);
    checkOutput("async_clr_err", 32'(bus.ERR), 32'h0);
    cdn = 1'b1;
    applyStimulus(0, 0, 1, 1, 8'h00);
    checkOutput("release_count", 32'(bus.Q), 32'h01);

    // Decade rollover of the low digit
    applyStimulus(1, 0, 0, 0, 8'h00);
    repeat (10) applyStimulus(0, 0, 1, 1, 8'h00);
    checkOutput("ten_edges", 32'(bus.Q), 32'h10);
    applyStimulus(0, 1, 0, 0, 8'h09);
    applyStimulus(0, 0, 1, 1, 8'h00);
    checkOutput("09_to_10", 32'(bus.Q), 32'h10);

    // Full wrap and carry-out
    applyStimulus(0, 1, 0, 0, 8'h98);
    applyStimulus(0, 0, 1, 1, 8'h00);
    checkOutput("at_99", 32'(bus.Q), 32'h99);
    checkOutput("co_at_99", 32'(bus.CO), 32'h1);
    applyStimulus(0, 0, 1, 1, 8'h00);
    checkOutput("wrap_00", 32'(bus.Q), 32'h00);
    checkOutput("co_after_wrap", 32'(bus.CO), 32'h0);

    // Priority among CS, LD and EN
    applyStimulus(0, 1, 0, 0, 8'h21);
    applyStimulus(1, 1, 1, 1, 8'h55);
    checkOutput("cs_wins", 32'(bus.Q), 32'h00);
    applyStimulus(0, 1, 1, 1, 8'h55);
    checkOutput("ld_wins", 32'(bus.Q), 32'h55);

    // Non-BCD load freezes counting until valid data is loaded
    applyStimulus(0, 1, 0, 0, 8'h3A);
    checkOutput("bad_load_q",   32'(bus.Q),   32'h3A);
    checkOutput("bad_load_err", 32'(bus.ERR), 32'h1);
    repeat (5) applyStimulus(0, 0, 1, 1, 8'h00);
    checkOutput("frozen_q",  32'(bus.Q),  32'h3A);
    checkOutput("frozen_co", 32'(bus.CO), 32'h0);
    applyStimulus(0, 1, 0, 0, 8'h12);
    checkOutput("recover_err", 32'(bus.ERR), 32'h0);
    applyStimulus(0, 0, 1, 1, 8'h00);
    checkOutput("resume_13", 32'(bus.Q), 32'h13);
    applyStimulus(0, 1, 0, 0, 8'h9A);
    applyStimulus(0, 0, 1, 1, 8'h00);
    checkOutput("frozen_9a", 32'(bus.Q), 32'h9A);
    checkOutput("co_9a", 32'(bus.CO), 32'h0);

    // Enable and carry-in gating
    applyStimulus(0, 1, 0, 0, 8'h99);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("ci0_hold", 32'(bus.Q), 32'h99);
    checkOutput("ci0_co",   32'(bus.CO), 32'h0);
    applyStimulus(0, 0, 0, 1, 8'h00);
    checkOutput("en0_hold", 32'(bus.Q), 32'h99);
    checkOutput("en0_co",   32'(bus.CO), 32'h0);

    // Two cascaded stages: 0x0999 -> 0x1000 on one edge
    @(negedge clk);
    #1;
    lo_if.LD = 1'b1; lo_if.D = 8'h99;
    hi_if.LD = 1'b1; hi_if.D = 8'h09;
    @(negedge clk);
    #1;
    lo_if.LD = 1'b0; lo_if.EN = 1'b1; lo_if.CI = 1'b1;
    hi_if.LD = 1'b0; hi_if.EN = 1'b1;
    #1;
    checkOutput("cascade_lo_co", 32'(lo_if.CO), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("cascade_1000", 32'({hi_if.Q, lo_if.Q}), 32'h1000);
    lo_if.EN = 1'b0;
    hi_if.EN = 1'b0;

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(3) != 0) rd = {4'($urandom_range(9)), 4'($urandom_range(9))};
      else                        rd = 8'($urandom);
      applyStimulus($urandom_range(19) == 0, $urandom_range(7) == 0,
                    $urandom_range(3) != 0, $urandom_range(4) != 0, rd);
    end

    applyStimulus(0, 0, 0, 0, 8'h00);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
